// File: rtl/ex_stage_pkg.sv
// Shared encodings and types for the RV32IM execute stage.
package ex_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MD_CYCLES = 32;
    localparam int unsigned CNT_W     = $clog2(MD_CYCLES);

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } aluop_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } mdop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
    } exmem_ctrl_t;

    // x0 is never forwarded; EX/MEM wins over MEM/WB when both are flagged.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0]      code,
                                                input logic [4:0]      rs,
                                                input logic [XLEN-1:0] reg_val,
                                                input logic [XLEN-1:0] exmem_val,
                                                input logic [XLEN-1:0] memwb_val);
        fwd_sel = reg_val;
        if (rs != 5'd0) begin
            if ((code & FWD_EXMEM) != FWD_REG) begin
                fwd_sel = exmem_val;
            end else if (code == FWD_MEMWB) begin
                fwd_sel = memwb_val;
            end
        end
    endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative multiply/divide engine: magnitude shift-add / restoring divide with sign fix-up.
module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  mdop_e           i_op,
    input  exmem_ctrl_t     i_ctrl,
    output logic            o_stall_c,
    output logic            o_done_c,
    output logic [XLEN-1:0] o_result_c,
    output exmem_ctrl_t     o_ctrl
);

    md_state_e         r_state;
    md_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_dividend;
    mdop_e             r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    exmem_ctrl_t       r_ctrl;

    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    // Operand signedness decides whether magnitudes are taken at entry.
    assign w_sa    = (i_op == MD_MULH || i_op == MD_MULHSU || i_op == MD_DIV || i_op == MD_REM)
                     && i_a[XLEN-1];
    assign w_sb    = (i_op == MD_MULH || i_op == MD_DIV || i_op == MD_REM) && i_b[XLEN-1];
    assign w_a_mag = w_sa ? -i_a : i_a;
    assign w_b_mag = w_sb ? -i_b : i_b;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_div} : {(XLEN+1){1'b0}});
    assign w_shift   = {r_hi, r_lo[XLEN-1]};
    assign w_ge      = w_shift >= {1'b0, r_div};
    assign w_sub     = w_shift[XLEN-1:0] - r_div;

    always_comb begin
        w_state_nxt = r_state;
        o_stall_c   = 1'b0;
        o_done_c    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CALC;
                    o_stall_c   = 1'b1;
                end
            end
            S_CALC: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    o_stall_c = 1'b1;
                    if (r_cnt == CNT_W'(MD_CYCLES - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                o_done_c    = !i_abort;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div      <= '0;
            r_dividend <= '0;
            r_op       <= MD_MUL;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ctrl     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_cnt      <= '0;
                r_hi       <= '0;
                r_lo       <= w_a_mag;
                r_div      <= w_b_mag;
                r_dividend <= i_a;
                r_op       <= i_op;
                r_neg_q    <= w_sa ^ w_sb;
                r_neg_r    <= w_sa;
                r_div0     <= (i_b == '0);
                r_ctrl     <= i_ctrl;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_op[2]) begin
                    r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_ge};
                end else begin
                    r_hi <= w_mul_sum[XLEN:1];
                    r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                end
            end
        end
    end

    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quot = r_neg_q ? -r_lo : r_lo;
    assign w_rem  = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        o_result_c = '0;
        case (r_op)
            MD_MUL:                        o_result_c = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  o_result_c = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               o_result_c = r_div0 ? '1 : w_quot;
            MD_REM, MD_REMU:               o_result_c = r_div0 ? r_dividend : w_rem;
            default:                       o_result_c = '0;
        endcase
    end

    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, inline ALU, mul/div engine and the EX/MEM register.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] IDEX_PC,
    input  logic [XLEN-1:0] IDEX_RS1_DATA,
    input  logic [XLEN-1:0] IDEX_RS2_DATA,
    input  logic [XLEN-1:0] IDEX_IMM,
    input  logic [4:0]      IDEX_RS,
    input  logic [4:0]      IDEX_RT,
    input  logic [4:0]      IDEX_RD,
    input  logic [3:0]      IDEX_ALUOP,
    input  logic            IDEX_ALUSRC_A,
    input  logic            IDEX_ALUSRC_B,
    input  logic            IDEX_MULDIV,
    input  logic [2:0]      IDEX_MDOP,
    input  logic            IDEX_REGWRITE,
    input  logic            IDEX_MEMREAD,
    input  logic            IDEX_MEMWRITE,
    input  logic            IDEX_MEMTOREG,
    input  logic [1:0]      FORWARD_A,
    input  logic [1:0]      FORWARD_B,
    input  logic [XLEN-1:0] MEMWB_WB_DATA,
    input  logic            FLUSH,
    output logic            STALL_REQ,
    output logic [XLEN-1:0] EXMEM_RESULT,
    output logic [XLEN-1:0] EXMEM_STORE_DATA,
    output logic [4:0]      EXMEM_RD,
    output logic            EXMEM_REGWRITE,
    output logic            EXMEM_MEMREAD,
    output logic            EXMEM_MEMWRITE,
    output logic            EXMEM_MEMTOREG
);

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    exmem_ctrl_t     w_idex_ctrl;
    logic            w_md_start;
    logic            w_md_stall;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;
    exmem_ctrl_t     w_md_ctrl;

    assign w_fwd_a = fwd_sel(FORWARD_A, IDEX_RS, IDEX_RS1_DATA, EXMEM_RESULT, MEMWB_WB_DATA);
    assign w_fwd_b = fwd_sel(FORWARD_B, IDEX_RT, IDEX_RS2_DATA, EXMEM_RESULT, MEMWB_WB_DATA);
    assign w_op_a  = IDEX_ALUSRC_A ? IDEX_PC : w_fwd_a;
    assign w_op_b  = IDEX_ALUSRC_B ? IDEX_IMM : w_fwd_b;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = '0;
        case (IDEX_ALUOP)
            ALU_ADD:   w_alu = w_op_a + w_op_b;
            ALU_SUB:   w_alu = w_op_a - w_op_b;
            ALU_SLL:   w_alu = w_op_a << w_shamt;
            ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
            ALU_XOR:   w_alu = w_op_a ^ w_op_b;
            ALU_SRL:   w_alu = w_op_a >> w_shamt;
            ALU_SRA:   w_alu = XLEN'($signed(w_op_a) >>> w_shamt);
            ALU_OR:    w_alu = w_op_a | w_op_b;
            ALU_AND:   w_alu = w_op_a & w_op_b;
            ALU_PASSB: w_alu = w_op_b;
            default:   w_alu = '0;
        endcase
    end

    assign w_idex_ctrl = {IDEX_RD, IDEX_REGWRITE, IDEX_MEMREAD, IDEX_MEMWRITE, IDEX_MEMTOREG};
    assign w_md_start  = IDEX_MULDIV && !FLUSH;

    muldiv_unit u_muldiv (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_start    (w_md_start),
        .i_abort    (FLUSH),
        .i_a        (w_fwd_a),
        .i_b        (w_fwd_b),
        .i_op       (mdop_e'(IDEX_MDOP)),
        .i_ctrl     (w_idex_ctrl),
        .o_stall_c  (w_md_stall),
        .o_done_c   (w_md_done),
        .o_result_c (w_md_result),
        .o_ctrl     (w_md_ctrl)
    );

    // Stall is combinational so the front end holds in the very cycle mul/div enters.
    assign STALL_REQ = w_md_stall;

    always_ff @(posedge CLK) begin
        if (RST || FLUSH || w_md_stall) begin
            EXMEM_RESULT     <= '0;
            EXMEM_STORE_DATA <= '0;
            EXMEM_RD         <= '0;
            EXMEM_REGWRITE   <= 1'b0;
            EXMEM_MEMREAD    <= 1'b0;
            EXMEM_MEMWRITE   <= 1'b0;
            EXMEM_MEMTOREG   <= 1'b0;
        end else if (w_md_done) begin
            EXMEM_RESULT     <= w_md_result;
            EXMEM_STORE_DATA <= '0;
            EXMEM_RD         <= w_md_ctrl.rd;
            EXMEM_REGWRITE   <= w_md_ctrl.regwrite;
            EXMEM_MEMREAD    <= w_md_ctrl.memread;
            EXMEM_MEMWRITE   <= w_md_ctrl.memwrite;
            EXMEM_MEMTOREG   <= w_md_ctrl.memtoreg;
        end else begin
            EXMEM_RESULT     <= w_alu;
            EXMEM_STORE_DATA <= w_fwd_b;
            EXMEM_RD         <= IDEX_RD;
            EXMEM_REGWRITE   <= IDEX_REGWRITE;
            EXMEM_MEMREAD    <= IDEX_MEMREAD;
            EXMEM_MEMWRITE   <= IDEX_MEMWRITE;
            EXMEM_MEMTOREG   <= IDEX_MEMTOREG;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IDEX_PC, IDEX_RS1_DATA, IDEX_RS2_DATA, IDEX_IMM;
    logic [4:0]  IDEX_RS, IDEX_RT, IDEX_RD;
    logic [3:0]  IDEX_ALUOP;
    logic        IDEX_ALUSRC_A, IDEX_ALUSRC_B, IDEX_MULDIV;
    logic [2:0]  IDEX_MDOP;
    logic        IDEX_REGWRITE, IDEX_MEMREAD, IDEX_MEMWRITE, IDEX_MEMTOREG;
    logic [1:0]  FORWARD_A, FORWARD_B;
    logic [31:0] MEMWB_WB_DATA;
    logic        FLUSH;
    logic        STALL_REQ;
    logic [31:0] EXMEM_RESULT, EXMEM_STORE_DATA;
    logic [4:0]  EXMEM_RD;
    logic        EXMEM_REGWRITE, EXMEM_MEMREAD, EXMEM_MEMWRITE, EXMEM_MEMTOREG;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_exmem;
    logic [8:0]  obs_ctrl;

    assign obs_ctrl = {EXMEM_RD, EXMEM_REGWRITE, EXMEM_MEMREAD, EXMEM_MEMWRITE, EXMEM_MEMTOREG};

    ex_stage dut (
        .CLK(CLK), .RST(RST),
        .IDEX_PC(IDEX_PC), .IDEX_RS1_DATA(IDEX_RS1_DATA), .IDEX_RS2_DATA(IDEX_RS2_DATA),
        .IDEX_IMM(IDEX_IMM), .IDEX_RS(IDEX_RS), .IDEX_RT(IDEX_RT), .IDEX_RD(IDEX_RD),
        .IDEX_ALUOP(IDEX_ALUOP), .IDEX_ALUSRC_A(IDEX_ALUSRC_A), .IDEX_ALUSRC_B(IDEX_ALUSRC_B),
        .IDEX_MULDIV(IDEX_MULDIV), .IDEX_MDOP(IDEX_MDOP),
        .IDEX_REGWRITE(IDEX_REGWRITE), .IDEX_MEMREAD(IDEX_MEMREAD),
        .IDEX_MEMWRITE(IDEX_MEMWRITE), .IDEX_MEMTOREG(IDEX_MEMTOREG),
        .FORWARD_A(FORWARD_A), .FORWARD_B(FORWARD_B), .MEMWB_WB_DATA(MEMWB_WB_DATA),
        .FLUSH(FLUSH), .STALL_REQ(STALL_REQ),
        .EXMEM_RESULT(EXMEM_RESULT), .EXMEM_STORE_DATA(EXMEM_STORE_DATA), .EXMEM_RD(EXMEM_RD),
        .EXMEM_REGWRITE(EXMEM_REGWRITE), .EXMEM_MEMREAD(EXMEM_MEMREAD),
        .EXMEM_MEMWRITE(EXMEM_MEMWRITE), .EXMEM_MEMTOREG(EXMEM_MEMTOREG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return sa >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, sp;
        logic [63:0]        up;
        logic signed [31:0] a32, b32, q;
        sa  = $signed({{32{a[31]}}, a});
        sb  = $signed({{32{b[31]}}, b});
        sub = $signed({32'd0, b});
        a32 = a;
        b32 = b;
        up  = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: return up[31:0];
            3'd1: begin sp = sa * sb;  return sp[63:32]; end
            3'd2: begin sp = sa * sub; return sp[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = a32 / b32;
                return q;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = a32 % b32;
                return q;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] code, input logic [4:0] rs,
                                            input logic [31:0] regv);
        if (rs == 5'd0) return regv;
        if (code >= 2'd2) return exp_exmem;
        if (code == 2'd1) return MEMWB_WB_DATA;
        return regv;
    endfunction

    task automatic drive_nop();
        IDEX_PC = '0; IDEX_RS1_DATA = '0; IDEX_RS2_DATA = '0; IDEX_IMM = '0;
        IDEX_RS = '0; IDEX_RT = '0; IDEX_RD = '0; IDEX_ALUOP = '0;
        IDEX_ALUSRC_A = 0; IDEX_ALUSRC_B = 0; IDEX_MULDIV = 0; IDEX_MDOP = '0;
        IDEX_REGWRITE = 0; IDEX_MEMREAD = 0; IDEX_MEMWRITE = 0; IDEX_MEMTOREG = 0;
        FORWARD_A = '0; FORWARD_B = '0; MEMWB_WB_DATA = '0; FLUSH = 0;
    endtask

    // Executes whatever ALU instruction is currently driven and checks the EX/MEM entry.
    task automatic alu_go(input string tag);
        logic [31:0] a, b, fb, e;
        logic [8:0]  ec;
        fb = ref_fwd(FORWARD_B, IDEX_RT, IDEX_RS2_DATA);
        a  = IDEX_ALUSRC_A ? IDEX_PC : ref_fwd(FORWARD_A, IDEX_RS, IDEX_RS1_DATA);
        b  = IDEX_ALUSRC_B ? IDEX_IMM : fb;
        e  = ref_alu(IDEX_ALUOP, a, b);
        ec = {IDEX_RD, IDEX_REGWRITE, IDEX_MEMREAD, IDEX_MEMWRITE, IDEX_MEMTOREG};
        tick();
        chk({tag, "_result"}, EXMEM_RESULT, e);
        chk({tag, "_store"}, EXMEM_STORE_DATA, fb);
        chk({tag, "_ctrl"}, 32'(obs_ctrl), 32'(ec));
        exp_exmem = e;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [4:0] rd);
        drive_nop();
        IDEX_ALUOP = op; IDEX_RS1_DATA = r1; IDEX_RS2_DATA = r2;
        IDEX_RS = rs; IDEX_RT = rt; FORWARD_A = fa; FORWARD_B = fb;
        IDEX_RD = rd; IDEX_REGWRITE = 1;
    endtask

    task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        drive_nop();
        IDEX_MULDIV = 1; IDEX_MDOP = op; IDEX_RS1_DATA = a; IDEX_RS2_DATA = b;
        IDEX_RS = 5'd1; IDEX_RT = 5'd2; IDEX_RD = rd; IDEX_REGWRITE = 1;
        IDEX_ALUOP = 4'($urandom_range(0, 10));
    endtask

    // Holds a mul/div instruction in ID/EX until the stall releases, then checks result and timing.
    task automatic md_go(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] e;
        int stalls, edges;
        bit done;
        e = ref_md(op, a, b);
        set_md(op, a, b, rd);
        #1;
        chk({tag, "_stall_entry"}, 32'(STALL_REQ), 32'd1);
        stalls = 1; edges = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            edges++;
            MEMWB_WB_DATA = $urandom;
            FORWARD_A = 2'b01;
            FORWARD_B = 2'b01;
            #1;
            if (STALL_REQ) stalls++;
            else done = 1;
            chk({tag, "_bubble"}, 32'(obs_ctrl), 32'd0);
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
        tick();
        edges++;
        drive_nop();
        chk({tag, "_result"}, EXMEM_RESULT, e);
        chk({tag, "_ctrl"}, 32'(obs_ctrl), 32'({rd, 4'b1000}));
        chk({tag, "_latency"}, 32'(edges), 32'd34);
        exp_exmem = e;
    endtask

    initial begin
        logic [31:0] ops [4];
        drive_nop();
        RST = 1;
        exp_exmem = '0;
        repeat (2) tick();
        chk("rst_result", EXMEM_RESULT, 32'd0);
        chk("rst_store", EXMEM_STORE_DATA, 32'd0);
        chk("rst_ctrl", 32'(obs_ctrl), 32'd0);
        RST = 0;
        #1;
        chk("rst_stall", 32'(STALL_REQ), 32'd0);

        // Forwarding priority and x0 suppression.
        set_alu(4'd0, 32'd2, 32'd3, 5'd1, 5'd2, 2'b00, 2'b00, 5'd4);
        alu_go("add_base");
        set_alu(4'd0, 32'd100, 32'd7, 5'd4, 5'd2, 2'b10, 2'b00, 5'd5);
        alu_go("add_fwd_exmem");
        set_alu(4'd0, 32'd1, 32'd2, 5'd1, 5'd2, 2'b00, 2'b00, 5'd6);
        alu_go("add_three");
        set_alu(4'd0, 32'd50, 32'd0, 5'd6, 5'd0, 2'b11, 2'b00, 5'd7);
        MEMWB_WB_DATA = 32'd9;
        alu_go("fwd11_exmem_prio");
        set_alu(4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b11, 2'b11, 5'd8);
        MEMWB_WB_DATA = 32'd9;
        alu_go("fwd_x0_suppress");
        set_alu(4'd0, 32'd0, 32'd0, 5'd3, 5'd0, 2'b00, 2'b00, 5'd9);
        IDEX_ALUSRC_A = 1; IDEX_ALUSRC_B = 1; IDEX_PC = 32'h1000; IDEX_IMM = 32'h2000;
        alu_go("auipc");
        set_alu(4'd10, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 2'b00, 5'd10);
        IDEX_ALUSRC_B = 1; IDEX_IMM = 32'hABCD_E000;
        alu_go("lui");

        for (int i = 0; i < 40; i++) begin
            set_alu(4'($urandom_range(0, 10)), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)));
            IDEX_ALUSRC_A = 1'($urandom_range(0, 1));
            IDEX_ALUSRC_B = 1'($urandom_range(0, 1));
            IDEX_PC = $urandom; IDEX_IMM = $urandom; MEMWB_WB_DATA = $urandom;
            IDEX_REGWRITE = 1'($urandom_range(0, 1)); IDEX_MEMREAD = 1'($urandom_range(0, 1));
            IDEX_MEMWRITE = 1'($urandom_range(0, 1)); IDEX_MEMTOREG = 1'($urandom_range(0, 1));
            alu_go("alu_rand");
        end

        // Directed mul/div corner cases.
        md_go("mul", 3'd0, 32'hFFFF_FFFF, 32'd2, 5'd11);
        md_go("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd12);
        md_go("mulh", 3'd1, 32'hFFFF_FFFF, 32'd2, 5'd13);
        md_go("div_by0", 3'd4, 32'd7, 32'd0, 5'd14);
        md_go("rem_by0", 3'd6, 32'd7, 32'd0, 5'd15);
        md_go("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        md_go("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd17);

        ops[0] = 32'd0; ops[1] = 32'hFFFF_FFFF; ops[2] = 32'h8000_0000; ops[3] = 32'd3;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom;
            md_go("md_rand", 3'($urandom_range(0, 7)), a, b, 5'($urandom_range(1, 31)));
        end

        // FLUSH in the 10th CALC cycle discards the result.
        set_md(3'd0, 32'd1234, 32'd5678, 5'd20);
        repeat (10) tick();
        FLUSH = 1;
        #1;
        chk("flush_stall_drop", 32'(STALL_REQ), 32'd0);
        tick();
        chk("flush_bubble", 32'(obs_ctrl), 32'd0);
        set_alu(4'd0, 32'd40, 32'd2, 5'd1, 5'd2, 2'b00, 2'b00, 5'd21);
        alu_go("flush_next_add");
        drive_nop();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("flush_no_result", 32'({STALL_REQ, EXMEM_REGWRITE}), 32'd0);
        end

        // RST mid-CALC aborts cleanly.
        set_md(3'd5, 32'd999, 32'd3, 5'd22);
        repeat (5) tick();
        RST = 1;
        tick();
        RST = 0;
        drive_nop();
        #1;
        chk("rst_mid_result", EXMEM_RESULT, 32'd0);
        chk("rst_mid_store", EXMEM_STORE_DATA, 32'd0);
        chk("rst_mid_ctrl", 32'(obs_ctrl), 32'd0);
        chk("rst_mid_stall", 32'(STALL_REQ), 32'd0);
        exp_exmem = '0;
        md_go("divu_after_rst", 3'd5, 32'd100, 32'd7, 5'd23);
        chk("divu_14", exp_exmem, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
